// File: rtl/mems_scan_pkg.sv
// Shared types and DAC frame helpers for the MEMS mirror scan controller.
package mems_scan_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_INIT_RST,
      ST_INIT_LDAC,
      ST_PT_WAIT,
      ST_PT_CALC,
      ST_CH_SEND
   } state_t;

   localparam logic [2:0]  CMD_SWRST  = 3'b101;
   localparam logic [2:0]  CMD_LDAC   = 3'b110;
   localparam logic [2:0]  CMD_WR     = 3'b000;
   localparam logic [2:0]  CMD_WRUPD  = 3'b010;

   localparam logic [15:0] SWRST_CODE = 16'h0001;
   localparam logic [15:0] LDAC_CODE  = 16'h000F;

   // 24-bit DAC word: two pad bits, command, channel address, 16-bit code
   function automatic logic [23:0] pack_frame(input logic [2:0]  cmd,
                                              input logic [2:0]  addr,
                                              input logic [15:0] code);
      return {2'b00, cmd, addr, code};
   endfunction

endpackage

// File: rtl/mems_axis_ramp.sv
// One scan axis: position register stepping between LO and HI, sawtooth or triangle.
module mems_axis_ramp #(
   parameter int DATA_W   = 8,
   parameter int LO       = 62,
   parameter int HI       = 122,
   parameter int STEP     = 1,
   parameter int TRIANGLE = 0
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step_en,
   output logic [DATA_W-1:0] pos,
   output logic [DATA_W-1:0] pos_c,
   output logic              wrap
);

   if (LO >= HI || STEP == 0 || STEP > HI - LO || HI >= (1 << DATA_W)) begin : g_bad_limits
      $error("mems_axis_ramp: illegal LO/HI/STEP combination");
   end

   localparam logic [DATA_W:0]   LO_X   = (DATA_W+1)'(LO);
   localparam logic [DATA_W:0]   HI_X   = (DATA_W+1)'(HI);
   localparam logic [DATA_W:0]   STEP_X = (DATA_W+1)'(STEP);
   localparam logic [DATA_W-1:0] LO_D   = DATA_W'(LO);
   localparam logic [DATA_W-1:0] HI_D   = DATA_W'(HI);
   localparam logic [DATA_W-1:0] STEP_D = DATA_W'(STEP);

   logic [DATA_W-1:0] pos_q, pos_nxt;
   logic              dir_dn_q, dir_dn_nxt;
   logic              at_end;
   logic [DATA_W:0]   up_sum;
   logic [DATA_W:0]   csum;

   assign up_sum = {1'b0, pos_q} + STEP_X;

   // Next position; a triangle turns on the point that reaches (or would pass) a limit,
   // so each limit is emitted exactly once per sweep
   always_comb begin
      pos_nxt    = up_sum[DATA_W-1:0];
      dir_dn_nxt = dir_dn_q;
      at_end     = 1'b0;
      if (TRIANGLE == 0) begin
         if (up_sum > HI_X) begin
            pos_nxt = LO_D;
            at_end  = 1'b1;
         end
      end else if (!dir_dn_q) begin
         if (up_sum >= HI_X) begin
            pos_nxt    = HI_D;
            dir_dn_nxt = 1'b1;
            at_end     = 1'b1;
         end
      end else begin
         if ({1'b0, pos_q} <= LO_X + STEP_X) begin
            pos_nxt    = LO_D;
            dir_dn_nxt = 1'b0;
            at_end     = 1'b1;
         end else begin
            pos_nxt    = pos_q - STEP_D;
         end
      end
   end

   // Position/direction state, reloaded to LO/up on every DAC init
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pos_q    <= LO_D;
         dir_dn_q <= 1'b0;
      end else if (load) begin
         pos_q    <= LO_D;
         dir_dn_q <= 1'b0;
      end else if (step_en) begin
         pos_q    <= pos_nxt;
         dir_dn_q <= dir_dn_nxt;
      end
   end

   // Present the post-step value during a step so the caller latches it the same cycle
   assign pos   = step_en ? pos_nxt : pos_q;
   assign wrap  = step_en & at_end;
   assign csum  = LO_X + HI_X - {1'b0, pos};
   assign pos_c = csum[DATA_W-1:0];

endmodule

// File: rtl/mems_scan_ctrl.sv
// MEMS mirror scan controller: DAC init, per-point differential ramp codes, SPI framing.
module mems_scan_ctrl
   import mems_scan_pkg::*;
#(
   parameter int NUM_AXES  = 2,
   parameter int DATA_W    = 8,
   parameter int FAST_LO   = 62,
   parameter int FAST_HI   = 122,
   parameter int SLOW_LO   = 62,
   parameter int SLOW_HI   = 122,
   parameter int FAST_STEP = 1,
   parameter int SLOW_STEP = 1,
   parameter int TRIANGLE  = 0,
   parameter int POINT_CYC = 0
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        mems_soft_reset,
   input  logic        stop,
   input  logic        pause,
   input  logic        mems_SPI_busy,
   input  logic        new_line_FIFO_done,
   input  logic        new_frame_FIFO_done,
   output logic        mems_SPI_start,
   output logic [23:0] data_miso,
   output logic        new_line,
   output logic        new_frame,
   output logic        scanning
);

   if (NUM_AXES < 1 || NUM_AXES > 2 || DATA_W < 1 || DATA_W > 16) begin : g_bad_params
      $error("mems_scan_ctrl: NUM_AXES must be 1..2 and DATA_W 1..16");
   end

   localparam int               NCH     = 2 * NUM_AXES;
   localparam logic [2:0]       LAST_CH = 3'(NCH - 1);
   localparam int               CNT_W   = $clog2(POINT_CYC + 2);
   localparam logic [CNT_W-1:0] CNT_MIN = CNT_W'(POINT_CYC);

   function automatic logic [15:0] left_justify(input logic [DATA_W-1:0] c);
      return 16'(c) << (16 - DATA_W);
   endfunction

   state_t            state;
   logic [2:0]        ch;
   logic [CNT_W-1:0]  cnt;
   logic              first;
   logic [DATA_W-1:0] code_q [4];

   logic              calc, load, can_start;
   logic              fast_step_en, fast_wrap, slow_wrap, frame_end, line_set;
   logic [DATA_W-1:0] fast_pos, fast_pos_c, slow_pos, slow_pos_c;

   assign calc         = (state == ST_PT_CALC);
   assign load         = (state == ST_IDLE) & mems_soft_reset;
   assign fast_step_en = calc & ~first;
   // Busy rises one cycle after start, so a start in the previous cycle also blocks
   assign can_start    = ~mems_SPI_busy & ~mems_SPI_start;

   mems_axis_ramp #(
      .DATA_W(DATA_W), .LO(FAST_LO), .HI(FAST_HI), .STEP(FAST_STEP), .TRIANGLE(TRIANGLE)
   ) u_fast (
      .clk(clk), .rst_n(rst_n), .load(load), .step_en(fast_step_en),
      .pos(fast_pos), .pos_c(fast_pos_c), .wrap(fast_wrap)
   );

   if (NUM_AXES == 2) begin : g_slow
      mems_axis_ramp #(
         .DATA_W(DATA_W), .LO(SLOW_LO), .HI(SLOW_HI), .STEP(SLOW_STEP), .TRIANGLE(TRIANGLE)
      ) u_slow (
         .clk(clk), .rst_n(rst_n), .load(load), .step_en(fast_wrap),
         .pos(slow_pos), .pos_c(slow_pos_c), .wrap(slow_wrap)
      );
   end else begin : g_no_slow
      assign slow_pos   = DATA_W'(SLOW_LO);
      assign slow_pos_c = DATA_W'(SLOW_HI);
      assign slow_wrap  = 1'b0;
   end

   // A frame end reports only new_frame; a plain line end reports new_line
   assign frame_end = (NUM_AXES == 2) ? slow_wrap : fast_wrap;
   assign line_set  = fast_wrap & ~frame_end;

   // Main sequencer: init frames, point pacing, channel streaming and boundary flags
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state          <= ST_IDLE;
         mems_SPI_start <= 1'b0;
         data_miso      <= '0;
         new_line       <= 1'b0;
         new_frame      <= 1'b0;
         scanning       <= 1'b0;
         ch             <= '0;
         cnt            <= '0;
         first          <= 1'b0;
         for (int i = 0; i < 4; i++) code_q[i] <= '0;
      end else begin
         mems_SPI_start <= 1'b0;
         new_line       <= line_set  | (new_line  & ~new_line_FIFO_done);
         new_frame      <= frame_end | (new_frame & ~new_frame_FIFO_done);
         if (calc)
            cnt <= CNT_W'(1);
         else if (cnt < CNT_MIN)
            cnt <= cnt + 1'b1;

         case (state)
            ST_IDLE: begin
               if (mems_soft_reset) state <= ST_INIT_RST;
            end
            ST_INIT_RST: begin
               if (can_start) begin
                  mems_SPI_start <= 1'b1;
                  data_miso      <= pack_frame(CMD_SWRST, 3'd0, SWRST_CODE);
                  state          <= ST_INIT_LDAC;
               end
            end
            ST_INIT_LDAC: begin
               if (can_start) begin
                  mems_SPI_start <= 1'b1;
                  data_miso      <= pack_frame(CMD_LDAC, 3'd0, LDAC_CODE);
                  state          <= ST_PT_WAIT;
                  scanning       <= 1'b1;
                  first          <= 1'b1;
                  cnt            <= CNT_MIN;
               end
            end
            ST_PT_WAIT: begin
               if (!pause && cnt >= CNT_MIN) state <= ST_PT_CALC;
            end
            ST_PT_CALC: begin
               code_q[0] <= fast_pos;
               code_q[1] <= fast_pos_c;
               code_q[2] <= slow_pos;
               code_q[3] <= slow_pos_c;
               first     <= 1'b0;
               ch        <= '0;
               state     <= ST_CH_SEND;
            end
            ST_CH_SEND: begin
               if (can_start) begin
                  mems_SPI_start <= 1'b1;
                  data_miso      <= pack_frame((ch == LAST_CH) ? CMD_WRUPD : CMD_WR, ch,
                                               left_justify(code_q[ch[1:0]]));
                  if (ch == LAST_CH) begin
                     if (stop) begin
                        state    <= ST_IDLE;
                        scanning <= 1'b0;
                     end else begin
                        state    <= ST_PT_WAIT;
                     end
                  end else begin
                     ch <= ch + 3'd1;
                  end
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
